// File: rtl/uart_hex_cmd_pkg.sv
// Shared constants for the UART hex command parser: ASCII codes and FSM state encodings.
package uart_hex_cmd_pkg;

  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_K     = 8'h4B;
  localparam logic [7:0] ASCII_QMARK = 8'h3F;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_DISCARD = 2'd2;

endpackage

// File: rtl/uart_hex_cmd_if.sv
// Byte links between the UART (rx strobe, tx valid/ready) and the command parser.
interface uart_hex_cmd_if;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;

  // master = UART side, slave = parser side
  modport master (output rx_valid, rx_data, tx_ready, input tx_valid, tx_data);
  modport slave  (input rx_valid, rx_data, tx_ready, output tx_valid, tx_data);
endinterface

// File: rtl/uart_hex_cmd_ascii_to_nibble.sv
// Combinational ASCII hex digit decoder; is_hex_o flags '0'-'9', 'a'-'f', 'A'-'F'.
module ascii_to_nibble (
  input  logic [7:0] ascii_i,
  output logic [3:0] nibble_o,
  output logic       is_hex_o
);
  always_comb begin
    nibble_o = 4'h0;
    is_hex_o = 1'b0;
    if (ascii_i >= 8'h30 && ascii_i <= 8'h39) begin
      nibble_o = ascii_i[3:0];
      is_hex_o = 1'b1;
    end else if ((ascii_i >= 8'h41 && ascii_i <= 8'h46) ||
                 (ascii_i >= 8'h61 && ascii_i <= 8'h66)) begin
      // low nibble of 'A'/'a' is 1, so +9 lands on 10
      nibble_o = ascii_i[3:0] + 4'd9;
      is_hex_o = 1'b1;
    end
  end
endmodule

// File: rtl/uart_hex_cmd.sv
// Parses terminated ASCII hex commands from the UART into a display word and answers ACK/NAK.
module uart_hex_cmd
  import uart_hex_cmd_pkg::*;
#(
  parameter int unsigned DIGITS    = 4,
  parameter logic [7:0]  TERM_CHAR = ASCII_CR,
  parameter logic [7:0]  ACK_CHAR  = ASCII_K,
  parameter logic [7:0]  NAK_CHAR  = ASCII_QMARK
) (
  input  logic                clk_i,
  input  logic                rst_i,
  uart_hex_cmd_if.slave       link,
  output logic [4*DIGITS-1:0] data_o,
  output logic                data_valid_o,
  output logic                err_o
);
  localparam int unsigned W  = 4 * DIGITS;
  localparam int unsigned CW = $clog2(DIGITS + 1);

  logic [1:0]    state_q, state_d;
  logic [W-1:0]  shadow_q, shadow_d;
  logic [CW-1:0] count_q, count_d;
  logic [W-1:0]  data_q, data_d;
  logic          data_valid_q, data_valid_d;
  logic          err_q, err_d;
  logic          tx_valid_q, tx_valid_d;
  logic [7:0]    tx_data_q, tx_data_d;

  logic [3:0] nibble;
  logic       is_hex, is_term, is_skip;
  logic       resp_req;
  logic [7:0] resp_byte;

  ascii_to_nibble u_a2n (
    .ascii_i  (link.rx_data),
    .nibble_o (nibble),
    .is_hex_o (is_hex)
  );

  assign is_term = (link.rx_data == TERM_CHAR);
  assign is_skip = !is_term && (link.rx_data == ASCII_LF || link.rx_data == ASCII_SPACE);

  always_comb begin
    state_d      = state_q;
    shadow_d     = shadow_q;
    count_d      = count_q;
    data_d       = data_q;
    data_valid_d = 1'b0;
    err_d        = 1'b0;
    resp_req     = 1'b0;
    resp_byte    = ACK_CHAR;
    if (link.rx_valid && !is_skip) begin
      case (state_q)
        ST_IDLE: begin
          if (is_hex) begin
            shadow_d = W'(nibble);
            count_d  = CW'(1);
            state_d  = ST_COLLECT;
          end else if (!is_term) begin
            state_d = ST_DISCARD;
          end
        end
        ST_COLLECT: begin
          if (is_term) begin
            data_d       = shadow_q;
            data_valid_d = 1'b1;
            resp_req     = 1'b1;
            resp_byte    = ACK_CHAR;
            state_d      = ST_IDLE;
          end else if (is_hex && count_q < CW'(DIGITS)) begin
            shadow_d = (shadow_q << 4) | W'(nibble);
            count_d  = count_q + CW'(1);
          end else begin
            state_d = ST_DISCARD;
          end
        end
        ST_DISCARD: begin
          if (is_term) begin
            err_d     = 1'b1;
            resp_req  = 1'b1;
            resp_byte = NAK_CHAR;
            state_d   = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // a response arriving while one is still pending is dropped
    tx_valid_d = tx_valid_q && !link.tx_ready;
    tx_data_d  = tx_data_q;
    if (resp_req && !tx_valid_q) begin
      tx_valid_d = 1'b1;
      tx_data_d  = resp_byte;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      shadow_q     <= '0;
      count_q      <= '0;
      data_q       <= '0;
      data_valid_q <= 1'b0;
      err_q        <= 1'b0;
      tx_valid_q   <= 1'b0;
      tx_data_q    <= 8'h00;
    end else begin
      state_q      <= state_d;
      shadow_q     <= shadow_d;
      count_q      <= count_d;
      data_q       <= data_d;
      data_valid_q <= data_valid_d;
      err_q        <= err_d;
      tx_valid_q   <= tx_valid_d;
      tx_data_q    <= tx_data_d;
    end
  end

  assign data_o        = data_q;
  assign data_valid_o  = data_valid_q;
  assign err_o         = err_q;
  assign link.tx_valid = tx_valid_q;
  assign link.tx_data  = tx_data_q;
endmodule

// File: tb/tb_uart_hex_cmd.sv
// Self-checking bench for uart_hex_cmd: command table, corner sequences, random traffic vs model.
module tb_uart_hex_cmd;
  localparam int DIGITS = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] data;
  logic        data_valid;
  logic        err;

  always #5 clk = ~clk;

  uart_hex_cmd_if link ();

  uart_hex_cmd #(.DIGITS(DIGITS)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .link         (link),
    .data_o       (data),
    .data_valid_o (data_valid),
    .err_o        (err)
  );

  int checks = 0;
  int errors = 0;
  byte got_q[$];

  // reference model: command text held as a list of digit values
  int          m_digits[$];
  bit          m_active, m_bad;
  logic [15:0] m_data;
  logic        m_dv, m_err, m_txv;
  logic [7:0]  m_txd;

  typedef struct {
    string       cmd;
    logic [15:0] exp_data;
    int          exp_resp;
  } vec_t;
  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int hex_value(input logic [7:0] c);
    if (c >= 8'h30 && c <= 8'h39) return int'(c) - 48;
    if (c >= 8'h41 && c <= 8'h46) return int'(c) - 65 + 10;
    if (c >= 8'h61 && c <= 8'h66) return int'(c) - 97 + 10;
    return -1;
  endfunction

  task automatic model_update(input logic rxv, input logic [7:0] rxd, input logic rdy, input logic r);
    int hv;
    int resp;
    int val;
    bit pend;
    if (r) begin
      m_digits.delete();
      m_active = 0; m_bad = 0;
      m_data = 16'h0; m_dv = 0; m_err = 0; m_txv = 0; m_txd = 8'h00;
      return;
    end
    pend = m_txv;
    resp = -1;
    m_dv = 0;
    m_err = 0;
    if (m_txv && rdy) m_txv = 0;
    if (rxv) begin
      hv = hex_value(rxd);
      if (rxd == 8'h0D) begin
        if (m_active) begin
          if (m_bad) begin
            m_err = 1;
            resp = 8'h3F;
          end else begin
            val = 0;
            foreach (m_digits[i]) val = val * 16 + m_digits[i];
            m_data = val[15:0];
            m_dv = 1;
            resp = 8'h4B;
          end
        end
        m_active = 0; m_bad = 0;
        m_digits.delete();
      end else if (rxd == 8'h0A || rxd == 8'h20) begin
      end else if (hv >= 0) begin
        if (!m_active) begin
          m_active = 1; m_bad = 0;
          m_digits.delete();
          m_digits.push_back(hv);
        end else if (!m_bad) begin
          if (m_digits.size() == DIGITS) m_bad = 1;
          else m_digits.push_back(hv);
        end
      end else begin
        m_active = 1; m_bad = 1;
      end
    end
    if (resp >= 0 && !pend) begin
      m_txv = 1;
      m_txd = resp[7:0];
    end
  endtask

  task automatic step(input logic rxv, input logic [7:0] rxd, input logic rdy, input logic r);
    @(negedge clk);
    rst = r;
    link.rx_valid = rxv;
    link.rx_data  = rxd;
    link.tx_ready = rdy;
    if (!r && link.tx_valid && rdy) got_q.push_back(link.tx_data);
    @(posedge clk);
    model_update(rxv, rxd, rdy, r);
    #1;
    check("data", 32'(data), 32'(m_data));
    check("data_valid", 32'(data_valid), 32'(m_dv));
    check("err", 32'(err), 32'(m_err));
    check("tx_valid", 32'(link.tx_valid), 32'(m_txv));
    check("tx_data", 32'(link.tx_data), 32'(m_txd));
  endtask

  task automatic send_str(input string s, input logic rdy);
    for (int i = 0; i < s.len(); i++) step(1'b1, s[i], rdy, 1'b0);
  endtask

  task automatic drain();
    repeat (3) step(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  initial begin
    string hs;
    logic  rxv, rdy, r;
    logic [7:0] b;
    int    sel;

    rst = 1'b1;
    link.rx_valid = 1'b0;
    link.rx_data  = 8'h00;
    link.tx_ready = 1'b0;

    vecs[0] = '{cmd: "12AB\015",     exp_data: 16'h12AB, exp_resp: 8'h4B};
    vecs[1] = '{cmd: "12G4\015",     exp_data: 16'h12AB, exp_resp: 8'h3F};
    vecs[2] = '{cmd: "7\015\012",    exp_data: 16'h0007, exp_resp: 8'h4B};
    vecs[3] = '{cmd: "12345\015",    exp_data: 16'h0007, exp_resp: 8'h3F};
    vecs[4] = '{cmd: "BEEF\015",     exp_data: 16'hBEEF, exp_resp: 8'h4B};
    vecs[5] = '{cmd: "3f\015",       exp_data: 16'h003F, exp_resp: 8'h4B};
    vecs[6] = '{cmd: " a b\015",     exp_data: 16'h00AB, exp_resp: 8'h4B};
    vecs[7] = '{cmd: "\015",         exp_data: 16'h00AB, exp_resp: -1};
    vecs[8] = '{cmd: "x1\015",       exp_data: 16'h00AB, exp_resp: 8'h3F};
    vecs[9] = '{cmd: "0000\015",     exp_data: 16'h0000, exp_resp: 8'h4B};

    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check("reset data", 32'(data), 32'h0);
    check("reset tx_valid", 32'(link.tx_valid), 32'h0);

    foreach (vecs[i]) begin
      got_q.delete();
      send_str(vecs[i].cmd, 1'b1);
      drain();
      check("vec data", 32'(data), 32'(vecs[i].exp_data));
      if (vecs[i].exp_resp < 0) begin
        check("vec resp count", 32'(got_q.size()), 32'd0);
      end else begin
        check("vec resp count", 32'(got_q.size()), 32'd1);
        if (got_q.size() > 0) check("vec resp byte", 32'(got_q[0]), 32'(vecs[i].exp_resp));
      end
    end

    // held-off transmitter: second ACK is dropped, first stays pending
    got_q.delete();
    send_str("1\015", 1'b0);
    send_str("2\015", 1'b0);
    check("backlog data", 32'(data), 32'h0002);
    check("backlog tx_valid", 32'(link.tx_valid), 32'h1);
    check("backlog tx_data", 32'(link.tx_data), 32'h4B);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check("backlog cleared", 32'(link.tx_valid), 32'h0);
    check("backlog resp count", 32'(got_q.size()), 32'd1);

    // reset mid-command discards the partial digits
    send_str("AB", 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b1);
    got_q.delete();
    send_str("C\015", 1'b1);
    drain();
    check("rst-mid data", 32'(data), 32'h000C);
    check("rst-mid resp count", 32'(got_q.size()), 32'd1);
    if (got_q.size() > 0) check("rst-mid resp byte", 32'(got_q[0]), 32'h4B);
    step(1'b0, 8'h00, 1'b1, 1'b1);
    check("rst alone data", 32'(data), 32'h0);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    hs = "0123456789abcdefABCDEF";
    repeat (3000) begin
      rxv = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 9);
      if (sel <= 4)      b = hs[$urandom_range(0, 21)];
      else if (sel <= 6) b = 8'h0D;
      else if (sel == 7) b = ($urandom_range(0, 1) == 0) ? 8'h0A : 8'h20;
      else               b = 8'($urandom_range(0, 255));
      rdy = ($urandom_range(0, 3) != 0);
      r   = ($urandom_range(0, 199) == 0);
      step(rxv, b, rdy, r);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
